// File: rtl/ftdi_tx_mass_pkg.sv
// ============================================================================
//  Module   : ftdi_tx_mass_pkg
//  Brief    : Shared encodings and LFSR step for the bulk transmit generator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ftdi_tx_mass_pkg;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    localparam logic [7:0] CONST_BYTE = 8'hA5;
    localparam logic [7:0] LFSR_TAPS  = 8'h71;

    typedef enum logic [0:0] {
        ST_CMD  = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Galois step for x^8+x^6+x^5+x^4+1: shift left, fold taps in on old MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ftdi_tx_mass_lfsr.sv
// ============================================================================
//  Module   : ftdi_tx_mass_lfsr
//  Brief    : Combinational B-step LFSR advance; lane i holds state after i steps.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ftdi_tx_mass_lfsr
    import ftdi_tx_mass_pkg::*;
#(
    parameter int B = 4
) (
    input  logic [7:0]     cur_state,
    output logic [8*B-1:0] lanes,
    output logic [7:0]     next_state
);

    logic [7:0] w_chain [0:B];

    assign w_chain[0] = cur_state;

    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_step
            assign lanes[8*gi +: 8] = w_chain[gi];
            assign w_chain[gi+1]    = lfsr_step(w_chain[gi]);
        end
    endgenerate

    assign next_state = w_chain[B];

endmodule

`default_nettype wire

// File: rtl/ftdi_tx_mass_gen.sv
// ============================================================================
//  Module   : ftdi_tx_mass_gen
//  Brief    : Command-driven bulk pattern generator (mode + length header in,
//             B-byte TX words out). TX_MASS_STATS_EN adds the xfer_cnt output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ftdi_tx_mass_gen
    import ftdi_tx_mass_pkg::*;
#(
    parameter int         TX_EW     = 2,
    parameter int         LEN_BYTES = 4,
    parameter logic [7:0] LFSR_SEED = 8'hFF
) (
    input  logic                      clk,
    input  logic                      rstn,
    output logic                      rx_tready,
    input  logic                      rx_tvalid,
    input  logic [7:0]                rx_tdata,
    input  logic                      tx_tready,
    output logic                      tx_tvalid,
    output logic [8*(1<<TX_EW)-1:0]   tx_tdata,
    output logic [(1<<TX_EW)-1:0]     tx_tkeep,
    output logic                      tx_tlast,
    output logic                      busy
`ifdef TX_MASS_STATS_EN
    ,
    output logic [31:0]               xfer_cnt
`endif
);

    localparam int B = 1 << TX_EW;
    localparam int L = 8 * LEN_BYTES;

    localparam logic [L-1:0] c_b_len    = L'(B);
    localparam logic [3:0]   c_last_idx = 4'(LEN_BYTES);

    state_t         r_state;
    logic [3:0]     r_hdr_idx;
    logic [1:0]     r_mode;
    logic [L-1:0]   r_len;
    logic [L-1:0]   r_rem;
    logic [7:0]     r_k;
    logic [7:0]     r_lfsr;

    logic           w_rx_fire;
    logic           w_tx_fire;
    logic           w_hdr_done;
    logic [L-1:0]   w_len_shift;

    logic [L-1:0]   w_src_rem;
    logic [7:0]     w_src_k;
    logic [7:0]     w_src_lfsr;
    logic [8*B-1:0] w_lfsr_lanes;
    logic [7:0]     w_lfsr_next;
    logic [8*B-1:0] w_data;
    logic [B-1:0]   w_keep;
    logic           w_last;
    logic [L-1:0]   w_rem_next;
    logic [7:0]     w_k_next;

    assign w_rx_fire  = rx_tvalid & rx_tready;
    assign w_tx_fire  = tx_tvalid & tx_tready;
    assign w_hdr_done = w_rx_fire && (r_hdr_idx == c_last_idx);

    // Length bytes arrive LSB first, so shifting right lands byte 1 at bit 0.
    generate
        if (LEN_BYTES == 1) begin : g_len_single
            assign w_len_shift = rx_tdata;
        end else begin : g_len_multi
            assign w_len_shift = {rx_tdata, r_len[L-1:8]};
        end
    endgenerate

    // One generator serves both the first word (fed from the fresh header)
    // and every following word (fed from the state left by the prior word).
    assign w_src_rem  = (r_state == ST_SEND) ? r_rem  : w_len_shift;
    assign w_src_k    = (r_state == ST_SEND) ? r_k    : 8'h00;
    assign w_src_lfsr = (r_state == ST_SEND) ? r_lfsr : LFSR_SEED;

    ftdi_tx_mass_lfsr #(
        .B (B)
    ) u_lfsr (
        .cur_state  (w_src_lfsr),
        .lanes      (w_lfsr_lanes),
        .next_state (w_lfsr_next)
    );

    always_comb begin
        w_data = '0;
        w_keep = '0;
        for (int i = 0; i < B; i++) begin
            w_keep[i] = (w_src_rem > L'(i));
            if (w_keep[i]) begin
                case (r_mode)
                    MODE_LFSR:  w_data[8*i +: 8] = w_lfsr_lanes[8*i +: 8];
                    MODE_CONST: w_data[8*i +: 8] = CONST_BYTE;
                    default:    w_data[8*i +: 8] = w_src_k + 8'(i);
                endcase
            end
        end
        w_last     = (w_src_rem <= c_b_len);
        w_rem_next = w_last ? '0 : (w_src_rem - c_b_len);
        w_k_next   = w_src_k + 8'(B);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_CMD;
            r_hdr_idx <= '0;
            r_mode    <= MODE_INC;
            r_len     <= '0;
            r_rem     <= '0;
            r_k       <= '0;
            r_lfsr    <= LFSR_SEED;
            rx_tready <= 1'b0;
            tx_tvalid <= 1'b0;
            tx_tdata  <= '0;
            tx_tkeep  <= '0;
            tx_tlast  <= 1'b0;
            busy      <= 1'b0;
`ifdef TX_MASS_STATS_EN
            xfer_cnt  <= '0;
`endif
        end else if (r_state == ST_CMD) begin
            rx_tready <= 1'b1;
            if (w_rx_fire) begin
                busy <= 1'b1;
                if (r_hdr_idx == 4'd0) begin
                    r_mode <= rx_tdata[1:0];
                end else begin
                    r_len <= w_len_shift;
                end
                if (w_hdr_done) begin
                    r_hdr_idx <= '0;
                    if (w_len_shift == '0) begin
                        busy <= 1'b0;
                    end else begin
                        rx_tready <= 1'b0;
                        r_state   <= ST_SEND;
                        tx_tvalid <= 1'b1;
                        tx_tdata  <= w_data;
                        tx_tkeep  <= w_keep;
                        tx_tlast  <= w_last;
                        r_rem     <= w_rem_next;
                        r_k       <= w_k_next;
                        r_lfsr    <= w_lfsr_next;
                    end
                end else begin
                    r_hdr_idx <= r_hdr_idx + 4'd1;
                end
            end
        end else begin
            rx_tready <= 1'b0;
            if (w_tx_fire) begin
                if (tx_tlast) begin
                    tx_tvalid <= 1'b0;
                    tx_tdata  <= '0;
                    tx_tkeep  <= '0;
                    tx_tlast  <= 1'b0;
                    busy      <= 1'b0;
                    rx_tready <= 1'b1;
                    r_state   <= ST_CMD;
`ifdef TX_MASS_STATS_EN
                    xfer_cnt  <= xfer_cnt + 32'd1;
`endif
                end else begin
                    tx_tdata  <= w_data;
                    tx_tkeep  <= w_keep;
                    tx_tlast  <= w_last;
                    r_rem     <= w_rem_next;
                    r_k       <= w_k_next;
                    r_lfsr    <= w_lfsr_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ftdi_tx_mass_gen.sv
// ============================================================================
//  Module   : tb_ftdi_tx_mass_gen
//  Brief    : Directed + randomized bench with a byte-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ftdi_tx_mass_gen;

    localparam int TX_EW     = 2;
    localparam int B         = 1 << TX_EW;
    localparam int LEN_BYTES = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             rx_tready;
    logic             rx_tvalid;
    logic [7:0]       rx_tdata;
    logic             tx_tready;
    logic             tx_tvalid;
    logic [8*B-1:0]   tx_tdata;
    logic [B-1:0]     tx_tkeep;
    logic             tx_tlast;
    logic             busy;
`ifdef TX_MASS_STATS_EN
    logic [31:0]      xfer_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_xfer = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ftdi_tx_mass_gen #(
        .TX_EW     (TX_EW),
        .LEN_BYTES (LEN_BYTES),
        .LFSR_SEED (8'hFF)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_tready (rx_tready),
        .rx_tvalid (rx_tvalid),
        .rx_tdata  (rx_tdata),
        .tx_tready (tx_tready),
        .tx_tvalid (tx_tvalid),
        .tx_tdata  (tx_tdata),
        .tx_tkeep  (tx_tkeep),
        .tx_tlast  (tx_tlast),
        .busy      (busy)
`ifdef TX_MASS_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream straight from the pattern rules.
    task automatic build_exp(input logic [1:0] m, input int n);
        logic [7:0] lf;
        lf = 8'hFF;
        exp_q.delete();
        for (int j = 0; j < n; j++) begin
            case (m)
                2'd1: begin
                    exp_q.push_back(lf);
                    lf = (lf << 1) ^ (lf[7] ? 8'h71 : 8'h00);
                end
                2'd2:    exp_q.push_back(8'hA5);
                default: exp_q.push_back(8'(j % 256));
            endcase
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_tvalid = 1'b1;
        rx_tdata  = b;
        while (rx_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        rx_tvalid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] mb, input logic [63:0] n);
        push_byte(mb);
        chk("busy_after_mode", busy, 1);
        for (int i = 0; i < LEN_BYTES; i++) push_byte(n[8*i +: 8]);
        if (n != 0) begin
            chk("first_valid_latency", tx_tvalid, 1);
        end else begin
            chk("zero_len_no_valid", tx_tvalid, 0);
            chk("zero_len_busy_low", busy, 0);
        end
    endtask

    // stall: 0 = always ready, 1 = toggle 1010..., 2 = random
    task automatic collect(input int n, input int stall);
        int nw, w, cyc;
        logic stalled, rdy, el;
        logic [8*B-1:0] hold_d, ed;
        logic [B-1:0]   hold_k, ek;
        logic           hold_l;
        nw = (n + B - 1) / B;
        w = 0; cyc = 0; stalled = 1'b0;
        while (w < nw && cyc < 2000) begin
            if (stalled) begin
                chk("stall_valid", tx_tvalid, 1);
                chk("stall_data", tx_tdata, hold_d);
                chk("stall_keep", tx_tkeep, hold_k);
                chk("stall_last", tx_tlast, hold_l);
            end
            if (rx_tvalid) chk("rx_held_off", rx_tready, 0);
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_tready = rdy;
            stalled = 1'b0;
            if (tx_tvalid === 1'b1) begin
                if (rdy) begin
                    ed = '0; ek = '0;
                    for (int i = 0; i < B; i++) begin
                        if (w * B + i < n) begin
                            ed[8*i +: 8] = exp_q[w * B + i];
                            ek[i] = 1'b1;
                        end
                    end
                    el = (w == nw - 1);
                    chk("word_data", tx_tdata, ed);
                    chk("word_keep", tx_tkeep, ek);
                    chk("word_last", tx_tlast, el);
                    chk("busy_in_send", busy, 1);
                    w++;
                end else begin
                    stalled = 1'b1;
                    hold_d = tx_tdata; hold_k = tx_tkeep; hold_l = tx_tlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (w < nw) chk("tx_timeout", 64'd0, 64'd1);
        tx_tready = 1'b0;
        chk("valid_drop_after_last", tx_tvalid, 0);
        chk("busy_low_after_last", busy, 0);
        exp_xfer++;
`ifdef TX_MASS_STATS_EN
        chk("xfer_cnt", xfer_cnt, 64'(exp_xfer));
`endif
    endtask

    task automatic run_cmd(input logic [7:0] mb, input int n, input int stall);
        send_hdr(mb, 64'(n));
        if (n > 0) begin
            build_exp(mb[1:0], n);
            collect(n, stall);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rmb;
        int         rn;
        rx_tvalid = 1'b0; rx_tdata = '0; tx_tready = 1'b0; rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_tready", rx_tready, 0);
        chk("rst_tx_tvalid", tx_tvalid, 0);
        chk("rst_tx_tdata", tx_tdata, 0);
        chk("rst_tx_tkeep", tx_tkeep, 0);
        chk("rst_tx_tlast", tx_tlast, 0);
        chk("rst_busy", busy, 0);
`ifdef TX_MASS_STATS_EN
        chk("rst_xfer_cnt", xfer_cnt, 0);
`endif
        rstn = 1'b1;
        chk("ready_before_edge", rx_tready, 0);
        @(negedge clk);
        chk("ready_after_release", rx_tready, 1);

        // Incrementing, 10 bytes -> 3 words, last keep 3
        run_cmd(8'h00, 10, 0);

        // Zero length: nothing emitted, count unchanged
        send_hdr(8'h00, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_len_idle_valid", tx_tvalid, 0);
        end
        chk("zero_len_ready", rx_tready, 1);
`ifdef TX_MASS_STATS_EN
        chk("zero_len_xfer_cnt", xfer_cnt, 64'(exp_xfer));
`endif

        // LFSR, 5 bytes
        run_cmd(8'h01, 5, 0);

        // Constant with toggling ready; next command's mode byte offered during SEND
        send_hdr(8'h02, 64'd8);
        build_exp(2'd2, 8);
        rx_tvalid = 1'b1;
        rx_tdata  = 8'h00;
        collect(8, 1);
        push_byte(8'h00);
        for (int i = 0; i < LEN_BYTES; i++) push_byte((i == 0) ? 8'd3 : 8'd0);
        chk("held_cmd_first_valid", tx_tvalid, 1);
        build_exp(2'd0, 3);
        collect(3, 0);

        // 300 bytes incrementing: byte 256 wraps
        run_cmd(8'h00, 300, 2);

        // Random modes (upper mode bits random), lengths and stalls
        for (int t = 0; t < 8; t++) begin
            rmb = 8'($urandom);
            rn  = $urandom_range(1, 40);
            run_cmd(rmb, rn, 2);
        end

        // Asynchronous reset in the middle of a 10-word transfer
        send_hdr(8'h00, 64'd40);
        tx_tready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", tx_tvalid, 0);
        chk("mid_rst_data", tx_tdata, 0);
        chk("mid_rst_keep", tx_tkeep, 0);
        chk("mid_rst_last", tx_tlast, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", rx_tready, 0);
        @(negedge clk);
        tx_tready = 1'b0;
        rstn = 1'b1;
        exp_xfer = 0;
        @(negedge clk);
        chk("post_rst_ready", rx_tready, 1);
        run_cmd(8'h01, 13, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
